// File: rtl/reg_sync_rf.sv
// Multi-ported register file: 16 x DATA_W general registers (R15 is the PC) plus CPSR.
// Optional same-cycle write forwarding to the read ports when REG_BYPASS_EN is defined.
module reg_sync_rf #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] in_address_1,
  input  logic [ADDR_W-1:0] in_address_2,
  input  logic [ADDR_W-1:0] in_address_3,
  input  logic [ADDR_W-1:0] in_address_4,
  output logic [DATA_W-1:0] out_data_1,
  output logic [DATA_W-1:0] out_data_2,
  output logic [DATA_W-1:0] out_data_3,
  output logic [DATA_W-1:0] out_data_4,
  input  logic [ADDR_W-1:0] write_address_1,
  input  logic [ADDR_W-1:0] write_address_2,
  input  logic [ADDR_W-1:0] write_address_3,
  input  logic [ADDR_W-1:0] write_address_4,
  input  logic [DATA_W-1:0] write_data_1,
  input  logic [DATA_W-1:0] write_data_2,
  input  logic [DATA_W-1:0] write_data_3,
  input  logic [DATA_W-1:0] write_data_4,
  input  logic              write_enable_1,
  input  logic              write_enable_2,
  input  logic              write_enable_3,
  input  logic              write_enable_4,
  input  logic [DATA_W-1:0] pc_update,
  input  logic              pc_write,
  input  logic [DATA_W-1:0] cspr_update,
  input  logic              cspr_write,
  output logic [DATA_W-1:0] pc,
  output logic [DATA_W-1:0] cspr
);

  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam int NUM_PORTS = 4;
  localparam logic [ADDR_W-1:0] PC_ADDR = ADDR_W'(NUM_REGS - 1);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [DATA_W-1:0] cspr_q;

  logic [ADDR_W-1:0] wr_addr [NUM_PORTS];
  logic [DATA_W-1:0] wr_data [NUM_PORTS];
  logic              wr_en   [NUM_PORTS];

  always_comb begin
    wr_addr[0] = write_address_1;
    wr_addr[1] = write_address_2;
    wr_addr[2] = write_address_3;
    wr_addr[3] = write_address_4;
    wr_data[0] = write_data_1;
    wr_data[1] = write_data_2;
    wr_data[2] = write_data_3;
    wr_data[3] = write_data_4;
    wr_en[0]   = write_enable_1;
    wr_en[1]   = write_enable_2;
    wr_en[2]   = write_enable_3;
    wr_en[3]   = write_enable_4;
  end

  // Later ports overwrite earlier ones, so port 4 wins a conflict; the
  // dedicated PC path is applied last so it beats any port write to R15.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      regs_d[r] = regs_q[r];
    end
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (wr_en[p]) begin
        regs_d[wr_addr[p]] = wr_data[p];
      end
    end
    if (pc_write) begin
      regs_d[PC_ADDR] = pc_update;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_q[r] <= '0;
      end
      cspr_q <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_q[r] <= regs_d[r];
      end
      if (cspr_write) begin
        cspr_q <= cspr_update;
      end
    end
  end

`ifdef REG_BYPASS_EN
  // Forwarding reads the next-state view, which already encodes write priority.
  assign out_data_1 = regs_d[in_address_1];
  assign out_data_2 = regs_d[in_address_2];
  assign out_data_3 = regs_d[in_address_3];
  assign out_data_4 = regs_d[in_address_4];
`else
  assign out_data_1 = regs_q[in_address_1];
  assign out_data_2 = regs_q[in_address_2];
  assign out_data_3 = regs_q[in_address_3];
  assign out_data_4 = regs_q[in_address_4];
`endif

  assign pc   = regs_q[PC_ADDR];
  assign cspr = cspr_q;

endmodule

// File: tb/tb_reg_sync_rf.sv
// Directed self-checking bench for reg_sync_rf; honours REG_BYPASS_EN for read-during-write.
module tb_reg_sync_rf;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [ADDR_W-1:0] in_address_1, in_address_2, in_address_3, in_address_4;
  logic [DATA_W-1:0] out_data_1, out_data_2, out_data_3, out_data_4;
  logic [ADDR_W-1:0] write_address_1, write_address_2, write_address_3, write_address_4;
  logic [DATA_W-1:0] write_data_1, write_data_2, write_data_3, write_data_4;
  logic              write_enable_1, write_enable_2, write_enable_3, write_enable_4;
  logic [DATA_W-1:0] pc_update, cspr_update, pc, cspr;
  logic              pc_write, cspr_write;

  int checks = 0;
  int failures = 0;

  reg_sync_rf #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_address_1(in_address_1), .in_address_2(in_address_2),
    .in_address_3(in_address_3), .in_address_4(in_address_4),
    .out_data_1(out_data_1), .out_data_2(out_data_2),
    .out_data_3(out_data_3), .out_data_4(out_data_4),
    .write_address_1(write_address_1), .write_address_2(write_address_2),
    .write_address_3(write_address_3), .write_address_4(write_address_4),
    .write_data_1(write_data_1), .write_data_2(write_data_2),
    .write_data_3(write_data_3), .write_data_4(write_data_4),
    .write_enable_1(write_enable_1), .write_enable_2(write_enable_2),
    .write_enable_3(write_enable_3), .write_enable_4(write_enable_4),
    .pc_update(pc_update), .pc_write(pc_write),
    .cspr_update(cspr_update), .cspr_write(cspr_write),
    .pc(pc), .cspr(cspr)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic idle_inputs();
    write_enable_1 = 1'b0; write_enable_2 = 1'b0;
    write_enable_3 = 1'b0; write_enable_4 = 1'b0;
    write_address_1 = '0; write_address_2 = '0;
    write_address_3 = '0; write_address_4 = '0;
    write_data_1 = '0; write_data_2 = '0; write_data_3 = '0; write_data_4 = '0;
    pc_write = 1'b0; pc_update = '0;
    cspr_write = 1'b0; cspr_update = '0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    write_enable_1 = 1'b1; write_address_1 = 4'd0; write_data_1 = 32'hFFFF_FFFF;
    pc_write = 1'b1; pc_update = 32'h0000_0055;
    cspr_write = 1'b1; cspr_update = 32'hAAAA_AAAA;
    @(posedge clk);
    @(negedge clk);
    idle_inputs();
    in_address_1 = 4'd0; in_address_2 = 4'd1; in_address_3 = 4'd15; in_address_4 = 4'd9;
    #1;
    checks++;
    if (out_data_1 !== 32'h0) begin
      failures++; $display("[TB] FAIL reset_r0: got %h expected %h", out_data_1, 32'h0);
    end
    checks++;
    if (out_data_2 !== 32'h0) begin
      failures++; $display("[TB] FAIL reset_r1: got %h expected %h", out_data_2, 32'h0);
    end
    checks++;
    if (out_data_3 !== 32'h0) begin
      failures++; $display("[TB] FAIL reset_r15: got %h expected %h", out_data_3, 32'h0);
    end
    checks++;
    if (out_data_4 !== 32'h0) begin
      failures++; $display("[TB] FAIL reset_r9: got %h expected %h", out_data_4, 32'h0);
    end
    checks++;
    if (pc !== 32'h0) begin
      failures++; $display("[TB] FAIL reset_pc: got %h expected %h", pc, 32'h0);
    end
    checks++;
    if (cspr !== 32'h0) begin
      failures++; $display("[TB] FAIL reset_cspr: got %h expected %h", cspr, 32'h0);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic_write();
    @(negedge clk);
    write_enable_1 = 1'b1; write_address_1 = 4'd0; write_data_1 = 32'h0000_0002;
    write_enable_2 = 1'b1; write_address_2 = 4'd1; write_data_2 = 32'h0000_0001;
    @(posedge clk);
    @(negedge clk);
    idle_inputs();
    in_address_1 = 4'd0; in_address_2 = 4'd1;
    #1;
    checks++;
    if (out_data_1 !== 32'h0000_0002) begin
      failures++; $display("[TB] FAIL basic_r0: got %h expected %h", out_data_1, 32'h2);
    end
    checks++;
    if (out_data_2 !== 32'h0000_0001) begin
      failures++; $display("[TB] FAIL basic_r1: got %h expected %h", out_data_2, 32'h1);
    end
  endtask

  task automatic test_write_conflict();
    @(negedge clk);
    write_enable_1 = 1'b1; write_address_1 = 4'd2; write_data_1 = 32'h11;
    write_enable_2 = 1'b1; write_address_2 = 4'd2; write_data_2 = 32'h22;
    write_enable_3 = 1'b1; write_address_3 = 4'd2; write_data_3 = 32'h33;
    write_enable_4 = 1'b1; write_address_4 = 4'd2; write_data_4 = 32'h44;
    @(posedge clk);
    @(negedge clk);
    idle_inputs();
    write_enable_1 = 1'b1; write_address_1 = 4'd8; write_data_1 = 32'hA1;
    write_enable_3 = 1'b1; write_address_3 = 4'd8; write_data_3 = 32'hA3;
    @(posedge clk);
    @(negedge clk);
    idle_inputs();
    in_address_1 = 4'd2; in_address_2 = 4'd8;
    #1;
    checks++;
    if (out_data_1 !== 32'h44) begin
      failures++; $display("[TB] FAIL conflict_all4: got %h expected %h", out_data_1, 32'h44);
    end
    checks++;
    if (out_data_2 !== 32'hA3) begin
      failures++; $display("[TB] FAIL conflict_p1_p3: got %h expected %h", out_data_2, 32'hA3);
    end
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      in_address_1 = 4'd2;
      #1;
      write_enable_1 = 1'b1; write_address_1 = 4'd2; write_data_1 = out_data_1 * 1;
      @(posedge clk);
      #1;
      checks++;
      if (out_data_1 !== 32'h44) begin
        failures++; $display("[TB] FAIL conflict_stable[%0d]: got %h expected %h", i, out_data_1, 32'h44);
      end
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_pc_priority();
    @(negedge clk);
    pc_write = 1'b1; pc_update = 32'h100;
    write_enable_3 = 1'b1; write_address_3 = 4'd15; write_data_3 = 32'h200;
    @(posedge clk);
    @(negedge clk);
    idle_inputs();
    in_address_1 = 4'd15;
    #1;
    checks++;
    if (pc !== 32'h100) begin
      failures++; $display("[TB] FAIL pc_priority_pc: got %h expected %h", pc, 32'h100);
    end
    checks++;
    if (out_data_1 !== 32'h100) begin
      failures++; $display("[TB] FAIL pc_priority_read15: got %h expected %h", out_data_1, 32'h100);
    end
    write_enable_2 = 1'b1; write_address_2 = 4'd15; write_data_2 = 32'h300;
    write_enable_4 = 1'b1; write_address_4 = 4'd15; write_data_4 = 32'h400;
    @(posedge clk);
    @(negedge clk);
    idle_inputs();
    #1;
    checks++;
    if (pc !== 32'h400) begin
      failures++; $display("[TB] FAIL pc_port_write: got %h expected %h", pc, 32'h400);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    checks++;
    if (pc !== 32'h400) begin
      failures++; $display("[TB] FAIL pc_hold: got %h expected %h", pc, 32'h400);
    end
  endtask

  task automatic test_cspr();
    @(negedge clk);
    cspr_write = 1'b1; cspr_update = 32'hF000_0000;
    @(posedge clk);
    @(negedge clk);
    idle_inputs();
    #1;
    checks++;
    if (cspr !== 32'hF000_0000) begin
      failures++; $display("[TB] FAIL cspr_load: got %h expected %h", cspr, 32'hF0000000);
    end
    cspr_update = 32'h1234_5678;
    @(posedge clk);
    @(posedge clk);
    #1;
    checks++;
    if (cspr !== 32'hF000_0000) begin
      failures++; $display("[TB] FAIL cspr_hold: got %h expected %h", cspr, 32'hF0000000);
    end
    @(negedge clk);
    cspr_write = 1'b1; cspr_update = 32'hA5A5_5A5A;
    @(posedge clk);
    #1;
    checks++;
    if (cspr !== 32'hA5A5_5A5A) begin
      failures++; $display("[TB] FAIL cspr_allbits: got %h expected %h", cspr, 32'hA5A55A5A);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_read_during_write();
    logic [DATA_W-1:0] expect_pre;
    @(negedge clk);
    write_enable_1 = 1'b1; write_address_1 = 4'd3; write_data_1 = 32'h1234;
    @(posedge clk);
    @(negedge clk);
    write_data_1 = 32'hDEAD;
    in_address_1 = 4'd3;
    #1;
`ifdef REG_BYPASS_EN
    expect_pre = 32'hDEAD;
`else
    expect_pre = 32'h1234;
`endif
    checks++;
    if (out_data_1 !== expect_pre) begin
      failures++; $display("[TB] FAIL rdw_pre_edge: got %h expected %h", out_data_1, expect_pre);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_data_1 !== 32'hDEAD) begin
      failures++; $display("[TB] FAIL rdw_post_edge: got %h expected %h", out_data_1, 32'hDEAD);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_distinct_writes();
    @(negedge clk);
    write_enable_1 = 1'b1; write_address_1 = 4'd4; write_data_1 = 32'h0404_0404;
    write_enable_2 = 1'b1; write_address_2 = 4'd5; write_data_2 = 32'h0505_0505;
    write_enable_3 = 1'b1; write_address_3 = 4'd6; write_data_3 = 32'h0606_0606;
    write_enable_4 = 1'b1; write_address_4 = 4'd7; write_data_4 = 32'h0707_0707;
    @(posedge clk);
    @(negedge clk);
    idle_inputs();
    in_address_1 = 4'd7; in_address_2 = 4'd6; in_address_3 = 4'd5; in_address_4 = 4'd4;
    #1;
    checks++;
    if (out_data_1 !== 32'h0707_0707) begin
      failures++; $display("[TB] FAIL distinct_r7: got %h expected %h", out_data_1, 32'h07070707);
    end
    checks++;
    if (out_data_2 !== 32'h0606_0606) begin
      failures++; $display("[TB] FAIL distinct_r6: got %h expected %h", out_data_2, 32'h06060606);
    end
    checks++;
    if (out_data_3 !== 32'h0505_0505) begin
      failures++; $display("[TB] FAIL distinct_r5: got %h expected %h", out_data_3, 32'h05050505);
    end
    checks++;
    if (out_data_4 !== 32'h0404_0404) begin
      failures++; $display("[TB] FAIL distinct_r4: got %h expected %h", out_data_4, 32'h04040404);
    end
    in_address_1 = 4'd0; in_address_2 = 4'd2;
    #1;
    checks++;
    if (out_data_1 !== 32'h2) begin
      failures++; $display("[TB] FAIL distinct_r0_kept: got %h expected %h", out_data_1, 32'h2);
    end
    checks++;
    if (out_data_2 !== 32'h44) begin
      failures++; $display("[TB] FAIL distinct_r2_kept: got %h expected %h", out_data_2, 32'h44);
    end
  endtask

  task automatic test_reset_again();
    @(negedge clk);
    rst_n = 1'b0;
    write_enable_4 = 1'b1; write_address_4 = 4'd4; write_data_4 = 32'hBEEF;
    @(posedge clk);
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
    in_address_1 = 4'd4; in_address_2 = 4'd15;
    #1;
    checks++;
    if (out_data_1 !== 32'h0) begin
      failures++; $display("[TB] FAIL reset_override_r4: got %h expected %h", out_data_1, 32'h0);
    end
    checks++;
    if (pc !== 32'h0 || cspr !== 32'h0) begin
      failures++; $display("[TB] FAIL reset_override_pc_cspr: got pc=%h cspr=%h expected 0", pc, cspr);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    in_address_1 = '0; in_address_2 = '0; in_address_3 = '0; in_address_4 = '0;
    test_reset();
    test_basic_write();
    test_write_conflict();
    test_pc_priority();
    test_cspr();
    test_read_during_write();
    test_distinct_writes();
    test_reset_again();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
